// File: rtl/load_level_pkg.sv
// Shared definitions for the load-level counter and its hysteresis alarm.
package load_level_pkg;

    // Alarm state encoding; the alarm output is simply (state == ALM_ACTIVE).
    typedef enum logic {
        ALM_IDLE   = 1'b0,
        ALM_ACTIVE = 1'b1
    } alm_state_e;

    // Default parameter set matching the original 3-bit FSM's successor.
    localparam int DEF_WIDTH     = 4;
    localparam int DEF_MAX       = 12;
    localparam int DEF_THRESH_HI = 10;
    localparam int DEF_THRESH_LO = 4;

endpackage

// File: rtl/hysteresis_alarm.sv
// Two-state hysteresis alarm: sets at Q >= THRESH_HI, clears at Q <= THRESH_LO,
// holds in between. Reusable by any level monitor with a registered level.
module hysteresis_alarm
    import load_level_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int THRESH_HI = DEF_THRESH_HI,
    parameter int THRESH_LO = DEF_THRESH_LO
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] Q,
    output logic             alarm
);

    localparam logic [WIDTH-1:0] HI_Q = WIDTH'(THRESH_HI);
    localparam logic [WIDTH-1:0] LO_Q = WIDTH'(THRESH_LO);

    // Threshold legality is a configuration error, not a runtime condition.
    if (THRESH_LO < 0 || THRESH_LO >= THRESH_HI || THRESH_HI > (2 ** WIDTH) - 1) begin : g_bad_thresh
        $fatal(1, "hysteresis_alarm: illegal thresholds LO=%0d HI=%0d", THRESH_LO, THRESH_HI);
    end

    alm_state_e state;
    alm_state_e state_next;

    // State register with synchronous reset.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ALM_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode from the registered level.
    // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            ALM_IDLE:   if (Q >= HI_Q) state_next = ALM_ACTIVE;
            ALM_ACTIVE: if (Q <= LO_Q) state_next = ALM_IDLE;
            default:    state_next = ALM_IDLE;
        endcase
    end

    assign alarm = (state == ALM_ACTIVE);

endmodule

// File: rtl/load_level_counter.sv
// Saturating up/down load-level counter with direct load, enable, full/empty
// decodes, one-cycle overflow/underflow pulses and a hysteresis alarm.
module load_level_counter
    import load_level_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX       = DEF_MAX,
    parameter int THRESH_HI = DEF_THRESH_HI,
    parameter int THRESH_LO = DEF_THRESH_LO
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             X,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] Q,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    output logic             udf,
    output logic             alarm
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] STEP  = WIDTH'(1);

    // The ceiling must be reachable and representable, and the alarm set
    // level must not lie above it or the alarm could never fire.
    if (MAX < 1 || MAX > (2 ** WIDTH) - 1 || THRESH_HI > MAX) begin : g_bad_max
        $fatal(1, "load_level_counter: illegal MAX=%0d for WIDTH=%0d, THRESH_HI=%0d", MAX, WIDTH, THRESH_HI);
    end

    logic [WIDTH-1:0] load_clamped;

    // Loads above the ceiling are silently clamped to MAX.
    assign load_clamped = (load_val > MAX_Q) ? MAX_Q : load_val;

    // Level register and saturation pulses; priority reset > load > en > hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            Q   <= '0;
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            ovf <= 1'b0;
            udf <= 1'b0;
            if (load) begin
                Q <= load_clamped;
            end else if (en) begin
                if (X) begin
                    if (Q < MAX_Q) Q <= Q + STEP;
                    else           ovf <= 1'b1;
                end else begin
                    if (Q != '0) Q <= Q - STEP;
                    else         udf <= 1'b1;
                end
            end
        end
    end

    // Flags decode the registered level directly, so they track Q with no lag.
    assign full  = (Q == MAX_Q);
    assign empty = (Q == '0);

    hysteresis_alarm #(
        .WIDTH     (WIDTH),
        .THRESH_HI (THRESH_HI),
        .THRESH_LO (THRESH_LO)
    ) u_alarm (
        .clk   (clk),
        .reset (reset),
        .Q     (Q),
        .alarm (alarm)
    );

endmodule

// File: tb/tb_load_level_counter.sv
// Self-checking bench for load_level_counter: a hand-derived vector table for
// the directed scenarios, then randomized traffic against a behavioural model.
module tb_load_level_counter;

    localparam int W   = 4;
    localparam int MX  = 12;
    localparam int HI  = 10;
    localparam int LO  = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         X;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] Q;
    logic         full, empty, ovf, udf, alarm;

    load_level_counter #(
        .WIDTH(W), .MAX(MX), .THRESH_HI(HI), .THRESH_LO(LO)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .X(X), .load(load), .load_val(load_val),
        .Q(Q), .full(full), .empty(empty), .ovf(ovf), .udf(udf), .alarm(alarm)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       rst;
        bit       ld;
        bit [3:0] lv;
        bit       en;
        bit       x;
        int       q;
        bit       full;
        bit       empty;
        bit       ovf;
        bit       udf;
        bit       alarm;
    } vec_t;

    vec_t vecs[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    // Behavioural model state.
    int m_q;
    bit m_ovf, m_udf, m_alarm;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got Q/full/empty/ovf/udf/alarm=%0h, expected %0h", name, act, exp);
    endtask

    function automatic int pack(input int q, input bit f, input bit e, input bit o, input bit u, input bit a);
        return (q << 5) | (int'(f) << 4) | (int'(e) << 3) | (int'(o) << 2) | (int'(u) << 1) | int'(a);
    endfunction

    function automatic int dut_pack();
        return pack(int'(Q), full, empty, ovf, udf, alarm);
    endfunction

    task automatic row(input bit r, input bit l, input int lv, input bit e, input bit x,
                       input int q, input bit f, input bit em, input bit o, input bit u, input bit a);
        vec_t v;
        v.rst = r; v.ld = l; v.lv = 4'(lv); v.en = e; v.x = x;
        v.q = q; v.full = f; v.empty = em; v.ovf = o; v.udf = u; v.alarm = a;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs on the falling edge, then let the rising edge take them.
    task automatic drive(input bit r, input bit l, input bit [3:0] lv, input bit e, input bit x);
        @(negedge clk);
        reset = r; load = l; load_val = lv; en = e; X = x;
        @(posedge clk);
        #1;
    endtask

    // Spec rules in plain arithmetic; alarm looks at the level before this edge.
    task automatic model_step(input bit r, input bit l, input int lv, input bit e, input bit x);
        bit next_alarm;
        if (r) begin
            m_q = 0; m_ovf = 0; m_udf = 0; m_alarm = 0;
        end else begin
            next_alarm = m_alarm ? !(m_q <= LO) : (m_q >= HI);
            m_ovf = 0; m_udf = 0;
            if (l)           m_q = (lv > MX) ? MX : lv;
            else if (e && x) begin if (m_q == MX) m_ovf = 1; else m_q = m_q + 1; end
            else if (e)      begin if (m_q == 0)  m_udf = 1; else m_q = m_q - 1; end
            m_alarm = next_alarm;
        end
    endtask

    initial begin
        bit r, l, e, x;
        bit [3:0] lv;
        reset = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; X = 1'b0;

        // Reset, then count up 14 cycles: Q saturates at 12, ovf on the last two,
        // alarm rises the cycle after Q first reads 10.
        row(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        for (int k = 1; k <= 14; k++)
            row(0, 0, 0, 1, 1, (k > MX) ? MX : k, k >= 12, 0, k >= 13, 0, k >= 11);
        // Count down from 12: alarm holds until the cycle after Q=4; udf after reaching 0.
        for (int d = 1; d <= 13; d++)
            row(0, 0, 0, 1, 0, (12 - d < 0) ? 0 : 12 - d, 0, d >= 12, 0, d == 13, d < 9);
        // Load clamp overrides en; then load 3 (alarm sets from the previous 12), then hold.
        row(0, 1, 15, 1, 0, 12, 1, 0, 0, 0, 0);
        row(0, 1, 3,  0, 0, 3,  0, 0, 0, 0, 1);
        row(0, 0, 0,  0, 0, 3,  0, 0, 0, 0, 0);
        // Enable gating at Q=7 with X toggling.
        row(0, 1, 7,  0, 0, 7,  0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++)
            row(0, 0, 0, 0, k % 2, 7, 0, 0, 0, 0, 0);
        // Reset mid-operation beats a simultaneous load.
        row(0, 1, 11, 0, 0, 11, 0, 0, 0, 0, 0);
        row(0, 0, 0,  0, 0, 11, 0, 0, 0, 0, 1);
        row(1, 1, 5,  1, 1, 0,  0, 1, 0, 0, 0);
        // Hysteresis band: toggle 9/10, then loads inside the band keep the alarm.
        row(0, 1, 9,  0, 0, 9,  0, 0, 0, 0, 0);
        row(0, 0, 0,  1, 1, 10, 0, 0, 0, 0, 0);
        row(0, 0, 0,  1, 0, 9,  0, 0, 0, 0, 1);
        row(0, 0, 0,  1, 1, 10, 0, 0, 0, 0, 1);
        row(0, 0, 0,  1, 0, 9,  0, 0, 0, 0, 1);
        row(0, 1, 6,  0, 0, 6,  0, 0, 0, 0, 1);
        row(0, 1, 5,  0, 0, 5,  0, 0, 0, 0, 1);
        row(0, 1, 7,  0, 0, 7,  0, 0, 0, 0, 1);
        row(0, 1, 4,  0, 0, 4,  0, 0, 0, 0, 1);
        row(0, 0, 0,  0, 0, 4,  0, 0, 0, 0, 0);
        // ovf pulse is dropped the cycle enable goes low.
        row(0, 1, 12, 0, 0, 12, 1, 0, 0, 0, 0);
        row(0, 0, 0,  1, 1, 12, 1, 0, 1, 0, 1);
        row(0, 0, 0,  0, 1, 12, 1, 0, 0, 0, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].x);
            check($sformatf("vec%0d", i), dut_pack(),
                  pack(vecs[i].q, vecs[i].full, vecs[i].empty, vecs[i].ovf, vecs[i].udf, vecs[i].alarm));
        end

        // Randomized traffic with direction bursts so both rails are reached often.
        x = 1'b1;
        for (int i = 0; i < 600; i++) begin
            r  = (i == 0) || ($urandom_range(0, 63) == 0);
            l  = ($urandom_range(0, 9) == 0);
            lv = 4'($urandom_range(0, 15));
            e  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) x = ~x;
            model_step(r, l, int'(lv), e, x);
            drive(r, l, lv, e, x);
            check($sformatf("rand%0d", i), dut_pack(),
                  pack(m_q, m_q == MX, m_q == 0, m_ovf, m_udf, m_alarm));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
